rx_fifo_arbiter: RTL and testbench

RX_FIFO_ARBITER -- requirements
Module: rx_fifo_arbiter

---
 rtl/rx_fifo_arbiter.sv | 141 ++++++++++++++
 tb/tb_rx_fifo_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_arbiter.sv
// Round-robin burst reader draining two RX sample FIFOs into one stream; first word 3 clks after arbitration, then 1 word/clk.
// Reads are throttled so buffered + in-flight words never exceed the 2-entry buffer; out_ready_i low stalls without loss.
module rx_fifo_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_W    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_b_i,
  input  logic                    ch0_empty_i,
  input  logic                    ch1_empty_i,
  input  logic [2*DATA_WIDTH-1:0] ch0_data_i,
  input  logic [2*DATA_WIDTH-1:0] ch1_data_i,
  output logic                    ch0_rd_en_o,
  output logic                    ch1_rd_en_o,
  input  logic [1:0]              ch_en_i,
  input  logic [BURST_W-1:0]      burst_len_i,
  output logic [2*DATA_WIDTH-1:0] out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_ch_o,
  output logic                    out_first_o,
  output logic                    busy_o
);

  localparam int WW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, GAP = 2'd2} state_t;

  typedef struct packed {
    logic [WW-1:0] dat;
    logic          ch;
    logic          first;
  } entry_t;

  state_t             state_q, state_d;
  logic               sel_q, pri_q, pick_ch;
  logic [BURST_W-1:0] len_q, cnt_q, cnt_nxt;
  logic [1:0]         elig;
  logic               issue, pop, room;
  logic [2:0]         level;
  logic               rd_pend_q, rd_ch_q, rd_first_q;
  logic [1:0]         occ_q;
  entry_t             buf0_q, buf1_q, push_ent;

  assign elig    = ch_en_i & {~ch1_empty_i, ~ch0_empty_i};
  assign pick_ch = elig[pri_q] ? pri_q : ~pri_q;
  assign cnt_nxt = cnt_q + BURST_W'(1);

  // A word leaving this clk frees its slot, which keeps 1 word/clk with out_ready_i high.
  assign pop   = (occ_q != 2'd0) && out_ready_i;
  assign level = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign room  = (level < 3'd2);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|elig) state_d = BURST;
      end
      BURST: begin
        if (!elig[sel_q]) begin
          state_d = GAP;
        end else if (room) begin
          issue = 1'b1;
          if (cnt_nxt == len_q) state_d = GAP;
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ch0_rd_en_o = issue & ~sel_q;
  assign ch1_rd_en_o = issue & sel_q;
  assign busy_o      = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      pri_q      <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_ch_q    <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= issue;
      rd_ch_q    <= sel_q;
      rd_first_q <= (cnt_q == '0);
      if (state_q == IDLE && |elig) begin
        sel_q <= pick_ch;
        pri_q <= ~pick_ch;
        len_q <= burst_len_i;
        cnt_q <= '0;
      end else if (issue) begin
        cnt_q <= cnt_nxt;
      end
    end
  end

  assign push_ent = '{dat: (rd_ch_q ? ch1_data_i : ch0_data_i), ch: rd_ch_q, first: rd_first_q};

  // Head of the buffer always lives in buf0_q so the outputs are plain register reads.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      occ_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      case ({rd_pend_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) buf0_q <= push_ent;
          else               buf1_q <= push_ent;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= push_ent;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= push_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = buf0_q.dat;
  assign out_ch_o    = buf0_q.ch;
  assign out_first_o = buf0_q.first;

endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// Directed bench for rx_fifo_arbiter with behavioural FIFOs and a negedge monitor logging every transfer.
module tb_rx_fifo_arbiter;

  localparam int DW = 16;
  localparam int BW = 8;
  localparam int WW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          ch0_empty, ch1_empty;
  logic [WW-1:0] ch0_data = '0, ch1_data = '0;
  logic          ch0_rd_en, ch1_rd_en;
  logic [1:0]    ch_en = 2'b00;
  logic [BW-1:0] burst_len = 8'd4;
  logic [WW-1:0] out_data;
  logic          out_valid, out_ready = 1'b1, out_ch, out_first, busy;

  rx_fifo_arbiter #(.DATA_WIDTH(DW), .BURST_W(BW)) dut (
    .clk_i(clk), .rst_b_i(rst_b),
    .ch0_empty_i(ch0_empty), .ch1_empty_i(ch1_empty),
    .ch0_data_i(ch0_data), .ch1_data_i(ch1_data),
    .ch0_rd_en_o(ch0_rd_en), .ch1_rd_en_o(ch1_rd_en),
    .ch_en_i(ch_en), .burst_len_i(burst_len),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_ch_o(out_ch), .out_first_o(out_first), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // FIFO models: read data valid one clk after rd_en
  logic [WW-1:0] mem0 [0:1023];
  logic [WW-1:0] mem1 [0:1023];
  logic [9:0]    w0 = '0, r0 = '0, w1 = '0, r1 = '0;
  assign ch0_empty = (r0 == w0);
  assign ch1_empty = (r1 == w1);

  always @(posedge clk) begin
    if (ch0_rd_en) begin ch0_data <= mem0[r0]; r0 <= r0 + 10'd1; end
    if (ch1_rd_en) begin ch1_data <= mem1[r1]; r1 <= r1 + 10'd1; end
  end

  int total = 0, bad = 0;
  int cyc = 0, lat_idle = 0, outst = 0;
  int n_both = 0, n_bad_rd = 0, n_unstable = 0, n_over = 0, log_n = 0;
  logic [WW-1:0] log_dat [0:2047];
  logic          log_ch [0:2047];
  logic          log_first [0:2047];
  int            log_cyc [0:2047];
  int            log_lat [0:2047];
  logic          stall_p = 1'b0, ch_p = 1'b0, first_p = 1'b0;
  logic [WW-1:0] dat_p = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ch0_rd_en && ch1_rd_en) n_both <= n_both + 1;
    if ((ch0_rd_en && (ch0_empty || !ch_en[0])) || (ch1_rd_en && (ch1_empty || !ch_en[1])))
      n_bad_rd <= n_bad_rd + 1;
    if (!rst_b) begin
      outst   <= 0;
      stall_p <= 1'b0;
    end else begin
      if (!busy && |(ch_en & {~ch1_empty, ~ch0_empty})) lat_idle <= cyc;
      if (outst + ((ch0_rd_en || ch1_rd_en) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0) > 2)
        n_over <= n_over + 1;
      outst <= outst + ((ch0_rd_en || ch1_rd_en) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (stall_p && (!out_valid || out_data !== dat_p || out_ch !== ch_p || out_first !== first_p))
        n_unstable <= n_unstable + 1;
      stall_p <= out_valid && !out_ready;
      dat_p   <= out_data;
      ch_p    <= out_ch;
      first_p <= out_first;
      if (out_valid && out_ready && log_n < 2048) begin
        log_dat[log_n]   <= out_data;
        log_ch[log_n]    <= out_ch;
        log_first[log_n] <= out_first;
        log_cyc[log_n]   <= cyc;
        log_lat[log_n]   <= cyc - lat_idle;
        log_n            <= log_n + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit ch, input int n, input logic [WW-1:0] base);
    for (int i = 0; i < n; i++) begin
      if (!ch) begin mem0[w0] = base + WW'(i); w0 = w0 + 10'd1; end
      else     begin mem1[w1] = base + WW'(i); w1 = w1 + 10'd1; end
    end
  endtask

  task automatic do_reset();
    ch_en = 2'b00; out_ready = 1'b1; burst_len = 8'd4;
    rst_b = 1'b0;
    tick(2);
    w0 = r0; w1 = r1;
    rst_b = 1'b1;
    tick(1);
  endtask

  task automatic wait_log(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (log_n >= target) ok = 1'b1;
      else tick(1);
    end
    if (log_n >= target) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; ch_en = 2'b00; out_ready = 1'b1;
    tick(2);
    total++;
    if ({ch0_rd_en, ch1_rd_en, out_valid, out_first, out_ch, busy} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {ch0_rd_en, ch1_rd_en, out_valid, out_first, out_ch, busy});
    end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    rst_b = 1'b1;
    tick(4);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle got busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic_burst();
    int start; bit ok;
    bit ef [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [WW-1:0] base = 32'hA000_0000;
    do_reset();
    fill(1'b0, 6, base);
    burst_len = 8'd4;
    start = log_n;
    ch_en = 2'b01;
    tick(2);
    burst_len = 8'd1;
    wait_log(start + 6, 80, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout got=%0d want=6", log_n - start); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (log_dat[start+i] !== base + WW'(i) || log_ch[start+i] !== 1'b0 || log_first[start+i] !== ef[i]) begin
        bad++;
        $display("FAIL basic_word%0d got=%h/ch%b/f%b want=%h/ch0/f%b", i, log_dat[start+i],
                 log_ch[start+i], log_first[start+i], base + WW'(i), ef[i]);
      end
    end
    total++;
    if (log_lat[start] !== 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", log_lat[start]); end
    total++;
    if (log_lat[start+4] !== 3) begin bad++; $display("FAIL basic_latency2 got=%0d want=3", log_lat[start+4]); end
    total++;
    if (log_cyc[start+3] - log_cyc[start] !== 3) begin
      bad++; $display("FAIL basic_rate got=%0d want=3", log_cyc[start+3] - log_cyc[start]);
    end
    tick(6);
    total++;
    if (busy !== 1'b0 || log_n !== start + 6) begin
      bad++; $display("FAIL basic_end got busy=%b words=%0d want 0 6", busy, log_n - start);
    end
  endtask

  task automatic test_round_robin();
    int start, nb, b, wd; bit ok;
    logic [WW-1:0] exp;
    do_reset();
    fill(1'b0, 4, 32'h0A00_0000);
    fill(1'b1, 4, 32'h0B00_0000);
    burst_len = 8'd2;
    start = log_n; nb = n_both;
    ch_en = 2'b11;
    wait_log(start + 8, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rr_timeout got=%0d want=8", log_n - start); end
    for (int k = 0; k < 8; k++) begin
      b = k / 2;
      wd = (b / 2) * 2 + (k % 2);
      exp = ((b % 2) == 1 ? 32'h0B00_0000 : 32'h0A00_0000) + WW'(wd);
      total++;
      if (log_ch[start+k] !== 1'((b % 2)) || log_dat[start+k] !== exp || log_first[start+k] !== ((k % 2) == 0)) begin
        bad++;
        $display("FAIL rr_word%0d got=%h/ch%b/f%b want=%h/ch%0d/f%0d", k, log_dat[start+k],
                 log_ch[start+k], log_first[start+k], exp, b % 2, (k % 2) == 0);
      end
    end
    total++;
    if (n_both !== nb) begin bad++; $display("FAIL rr_dual_rd got=%0d want=0", n_both - nb); end
  endtask

  task automatic test_short_fifo();
    int start, nbr; bit ok;
    logic [WW-1:0] base = 32'hC100_0000;
    do_reset();
    fill(1'b1, 3, base);
    burst_len = 8'd8;
    start = log_n; nbr = n_bad_rd;
    ch_en = 2'b10;
    wait_log(start + 3, 40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL short_timeout got=%0d want=3", log_n - start); end
    tick(8);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (log_dat[start+i] !== base + WW'(i) || log_ch[start+i] !== 1'b1 || log_first[start+i] !== (i == 0)) begin
        bad++;
        $display("FAIL short_word%0d got=%h/ch%b/f%b want=%h/ch1/f%0d", i, log_dat[start+i],
                 log_ch[start+i], log_first[start+i], base + WW'(i), i == 0);
      end
    end
    total++;
    if (log_n !== start + 3) begin bad++; $display("FAIL short_count got=%0d want=3", log_n - start); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL short_busy got=%b want=0", busy); end
    total++;
    if (n_bad_rd !== nbr) begin bad++; $display("FAIL short_rd_empty got=%0d want=0", n_bad_rd - nbr); end
  endtask

  task automatic test_backpressure();
    int start, nu, no, nb, b, wd, errs; bit done;
    logic [WW-1:0] exp;
    do_reset();
    fill(1'b0, 100, 32'hD000_0000);
    fill(1'b1, 100, 32'hD100_0000);
    burst_len = 8'd5;
    start = log_n; nu = n_unstable; no = n_over; nb = n_both;
    ch_en = 2'b11;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      out_ready = ($urandom_range(0, 99) < 55);
      tick(1);
      if (log_n >= start + 200) done = 1'b1;
    end
    out_ready = 1'b1;
    total++;
    if (!done) begin bad++; $display("FAIL bp_timeout got=%0d want=200", log_n - start); end
    errs = 0;
    for (int k = 0; k < 200; k++) begin
      b = k / 5;
      wd = (b / 2) * 5 + (k % 5);
      exp = ((b % 2) == 1 ? 32'hD100_0000 : 32'hD000_0000) + WW'(wd);
      total++;
      if (log_dat[start+k] !== exp || log_ch[start+k] !== 1'((b % 2)) || log_first[start+k] !== ((k % 5) == 0)) begin
        bad++;
        if (errs < 5)
          $display("FAIL bp_word%0d got=%h/ch%b/f%b want=%h/ch%0d/f%0d", k, log_dat[start+k],
                   log_ch[start+k], log_first[start+k], exp, b % 2, (k % 5) == 0);
        errs++;
      end
    end
    total++;
    if (n_unstable !== nu) begin bad++; $display("FAIL bp_stable got=%0d want=0", n_unstable - nu); end
    total++;
    if (n_over !== no) begin bad++; $display("FAIL bp_occupancy got=%0d want=0", n_over - no); end
    total++;
    if (n_both !== nb) begin bad++; $display("FAIL bp_dual_rd got=%0d want=0", n_both - nb); end
  endtask

  task automatic test_long_burst();
    int start, nf; bit ok;
    logic [WW-1:0] base = 32'hE000_0000;
    do_reset();
    fill(1'b0, 300, base);
    burst_len = 8'd0;
    start = log_n;
    ch_en = 2'b01;
    wait_log(start + 300, 600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL long_timeout got=%0d want=300", log_n - start); end
    nf = 0;
    for (int i = 1; i < 256; i++) if (log_first[start+i] === 1'b1) nf++;
    total++;
    if (log_first[start] !== 1'b1 || nf !== 0) begin
      bad++; $display("FAIL long_first got=w0:%b inner=%0d want=w0:1 inner=0", log_first[start], nf);
    end
    total++;
    if (log_first[start+256] !== 1'b1) begin
      bad++; $display("FAIL long_next_burst got=%b want=1", log_first[start+256]);
    end
    total++;
    if (log_cyc[start+255] - log_cyc[start] !== 255) begin
      bad++; $display("FAIL long_rate got=%0d want=255", log_cyc[start+255] - log_cyc[start]);
    end
    total++;
    if (log_dat[start+255] !== base + WW'(255) || log_dat[start+299] !== base + WW'(299)) begin
      bad++; $display("FAIL long_data got=%h,%h want=%h,%h", log_dat[start+255], log_dat[start+299],
                      base + WW'(255), base + WW'(299));
    end
  endtask

  task automatic test_reset_mid_burst();
    int start, stale; bit ok;
    logic [WW-1:0] base = 32'hF000_0000;
    do_reset();
    fill(1'b0, 10, base);
    burst_len = 8'd8;
    out_ready = 1'b0;
    ch_en = 2'b01;
    tick(6);
    total++;
    if (out_valid !== 1'b1 || out_data !== base) begin
      bad++; $display("FAIL midrst_pre got=v%b/%h want=v1/%h", out_valid, out_data, base);
    end
    rst_b = 1'b0;
    #1;
    total++;
    if ({ch0_rd_en, ch1_rd_en, out_valid, out_first, out_ch, busy} !== 6'b0 || out_data !== '0) begin
      bad++; $display("FAIL midrst_outputs got=%b/%h want=000000/0",
                      {ch0_rd_en, ch1_rd_en, out_valid, out_first, out_ch, busy}, out_data);
    end
    tick(1);
    out_ready = 1'b1;
    start = log_n;
    rst_b = 1'b1;
    wait_log(start + 8, 60, ok);
    tick(6);
    total++;
    if (!ok || log_n !== start + 8) begin bad++; $display("FAIL midrst_count got=%0d want=8", log_n - start); end
    stale = 0;
    for (int i = start; i < log_n; i++) if (log_dat[i] === base || log_dat[i] === base + WW'(1)) stale++;
    total++;
    if (stale !== 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", stale); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (log_dat[start+k] !== base + WW'(k + 2) || log_first[start+k] !== (k == 0)) begin
        bad++; $display("FAIL midrst_word%0d got=%h/f%b want=%h/f%0d", k, log_dat[start+k],
                        log_first[start+k], base + WW'(k + 2), k == 0);
      end
    end
    total++;
    if (log_lat[start] !== 3) begin bad++; $display("FAIL midrst_resume got=%0d want=3", log_lat[start]); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_round_robin();
    test_short_fifo();
    test_backpressure();
    test_long_burst();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
